bsg_fpu_norm_shift: RTL and testbench

- Consumer side of the leading-zero count path.
- Takes an unnormalized mantissa, its exponent, and the leading-zero count produced by bsg_fpu_clz.
- Left-shifts the mantissa to normalize it and decrements the exponent. Limits the shift at exponent zero so the result is denormal instead of underflowing.
- Two-stage elastic pipeline with valid/ready input and valid/yumi output. Sits between the adder's clz stage and rounding.

---
 rtl/bsg_fpu_norm_shift.sv | 148 ++++++++++++++
 tb/tb_bsg_fpu_norm_shift.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bsg_fpu_norm_shift.sv
// bsg_fpu_norm_shift: normalizing left shifter for the FPU adder datapath.
// Takes an unnormalized mantissa, its biased exponent and its leading-zero
// count. It shifts the mantissa left and lowers the exponent to match. The
// shift is capped at the exponent, so a small exponent gives a denormal
// result instead of an underflow.
// Two-stage elastic pipeline: valid/ready on the input, valid/yumi on the
// output.
// Optional simulation checks are enabled with the macro
// BSG_FPU_NORM_SHIFT_CHECK_EN. They cover two cases:
//   - the shifted MSB is 0 after a shift that was not exponent-limited;
//   - yumi_i is asserted while v_o is low.
// With the macro undefined, no check logic is present.
module bsg_fpu_norm_shift #(
  parameter int width_p       = 16,
  parameter int exp_width_p   = 5,
  localparam int shamt_width_p = $clog2(width_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  output logic                     ready_o,
  input  logic [width_p-1:0]       data_i,
  input  logic [shamt_width_p-1:0] shamt_i,
  input  logic [exp_width_p-1:0]   exp_i,
  output logic                     v_o,
  input  logic                     yumi_i,
  output logic [width_p-1:0]       data_o,
  output logic [exp_width_p-1:0]   exp_o,
  output logic                     denorm_o,
  output logic                     zero_o
);

  // Common width for comparing shift count against exponent (zero-extended).
  localparam int cmp_w_lp = (exp_width_p > shamt_width_p) ? exp_width_p : shamt_width_p;

  // Stage valids
  logic r_s1_v;
  logic r_s2_v;

  // Stage 1 payload
  logic [width_p-1:0]       r_data;
  logic [shamt_width_p-1:0] r_eff;
  logic [exp_width_p-1:0]   r_exp;
  logic                     r_z;

  // Stage 2 payload (drives the outputs directly)
  logic [width_p-1:0]       r_data_o;
  logic [exp_width_p-1:0]   r_exp_o;
  logic                     r_denorm_o;
  logic                     r_zero_o;

  // Handshake and datapath wires
  logic                     w_s1_adv;
  logic                     w_accept;
  logic                     w_s2_load;
  logic [cmp_w_lp-1:0]      w_shamt_ext;
  logic [cmp_w_lp-1:0]      w_exp_ext;
  logic [cmp_w_lp-1:0]      w_eff_ext;
  logic [shamt_width_p-1:0] w_eff;
  logic [exp_width_p-1:0]   w_exp_adj;
  logic                     w_data_zero;
  logic [width_p-1:0]       w_shifted;
  logic [exp_width_p-1:0]   w_exp_out;

  // Stage 1 may hand off whenever stage 2 is empty or draining this cycle.
  // ready_o is a function of state and yumi_i only, never of v_i.
  assign w_s1_adv  = ~r_s2_v | yumi_i;
  assign ready_o   = ~r_s1_v | w_s1_adv;
  assign w_accept  = v_i & ready_o;
  assign w_s2_load = r_s1_v & w_s1_adv;

  // Effective shift = min(shamt, exp). It never exceeds either operand, so
  // narrowing it to either width is lossless and the exponent cannot wrap.
  assign w_shamt_ext = cmp_w_lp'(shamt_i);
  assign w_exp_ext   = cmp_w_lp'(exp_i);
  assign w_eff_ext   = (w_shamt_ext < w_exp_ext) ? w_shamt_ext : w_exp_ext;
  assign w_eff       = shamt_width_p'(w_eff_ext);
  assign w_exp_adj   = exp_i - exp_width_p'(w_eff_ext);
  assign w_data_zero = (data_i == '0);

  // The stage-2 shifter works on registered stage-1 values. This keeps the
  // compare/subtract and the barrel shift in separate cycles.
  assign w_shifted = r_data << r_eff;
  assign w_exp_out = r_z ? '0 : r_exp;

  // Valid bits: the only reset state. Reset drops every in-flight item.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
    end else begin
      r_s1_v <= w_accept | (r_s1_v & ~w_s1_adv);
      r_s2_v <= w_s2_load | (r_s2_v & ~yumi_i);
    end
  end

  // Stage 1 payload capture on accept. No reset; don't-care while invalid.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_data <= data_i;
      r_eff  <= w_eff;
      r_exp  <= w_exp_adj;
      r_z    <= w_data_zero;
    end
  end

  // Stage 2 payload load. The outputs hold while v_o=1 and yumi_i=0.
  always_ff @(posedge clk_i) begin
    if (w_s2_load) begin
      r_data_o   <= w_shifted;
      r_exp_o    <= w_exp_out;
      r_zero_o   <= r_z;
      r_denorm_o <= ~r_z & (w_exp_out == '0);
    end
  end

  assign v_o      = r_s2_v;
  assign data_o   = r_data_o;
  assign exp_o    = r_exp_o;
  assign denorm_o = r_denorm_o;
  assign zero_o   = r_zero_o;

`ifdef BSG_FPU_NORM_SHIFT_CHECK_EN
  // Keep the original inputs so a failed check can report them.
  logic [shamt_width_p-1:0] r_shamt_in;
  logic [exp_width_p-1:0]   r_exp_in;

  // Capture the original shift count and exponent alongside stage 1.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_shamt_in <= shamt_i;
      r_exp_in   <= exp_i;
    end
  end

  // Simulation-only protocol and normalization checks.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (w_s2_load && !r_z && (r_eff == r_shamt_in) && !w_shifted[width_p-1])
        $error("bsg_fpu_norm_shift: unnormalized result data=%h shamt=%0d exp=%0d",
               r_data, r_shamt_in, r_exp_in);
      if (yumi_i && !r_s2_v)
        $error("bsg_fpu_norm_shift: yumi_i asserted while v_o=0");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_fpu_norm_shift.sv
// Testbench for bsg_fpu_norm_shift. It has four parts:
//   - table vectors with hand-computed results;
//   - a stall/throughput sequence;
//   - a mid-flight reset sequence;
//   - randomized traffic checked against a queue-based reference model.
module tb_bsg_fpu_norm_shift;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        v_i;
  logic        ready_o;
  logic [15:0] data_i;
  logic [3:0]  shamt_i;
  logic [4:0]  exp_i;
  logic        v_o;
  logic        yumi_i;
  logic [15:0] data_o;
  logic [4:0]  exp_o;
  logic        denorm_o;
  logic        zero_o;

  bsg_fpu_norm_shift #(.width_p(16), .exp_width_p(5)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
    .data_i(data_i), .shamt_i(shamt_i), .exp_i(exp_i), .v_o(v_o),
    .yumi_i(yumi_i), .data_o(data_o), .exp_o(exp_o),
    .denorm_o(denorm_o), .zero_o(zero_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;

  // Expected results packed as {data[15:0], exp[4:0], denorm, zero}.
  logic [22:0] q[$];
  bit          hold_pending = 0;
  logic [22:0] hold_val;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  s;
    logic [4:0]  e;
    logic [15:0] xd;
    logic [4:0]  xe;
    logic        xdn;
    logic        xz;
  } vec_t;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Reference: normalize by min(shamt, exp) using plain integer arithmetic.
  function automatic logic [22:0] ref_norm(input int d, input int s, input int e);
    int eff;
    logic [31:0] dd;
    logic [31:0] ee;
    eff = (s < e) ? s : e;
    dd  = (d << eff) & 32'hFFFF;
    ee  = (d == 0) ? 0 : (e - eff);
    return {dd[15:0], ee[4:0], (d != 0) && (ee == 0), d == 0};
  endfunction

  function automatic int clz16(input logic [15:0] d);
    for (int i = 15; i >= 0; i--) if (d[i]) return 15 - i;
    return 0;
  endfunction

  // One clock cycle: drive at the negedge, evaluate the handshake 1ns later,
  // check against the model, then let the next posedge commit it.
  task automatic tick(input logic v, input logic [15:0] d, input logic [3:0] s,
                      input logic [4:0] e, input logic y, output bit acc);
    logic [22:0] got;
    logic [22:0] exp_item;
    bit          mready;
    @(negedge clk_i);
    v_i = v; data_i = d; shamt_i = s; exp_i = e;
    yumi_i = y & v_o;
    #1;
    got = {data_o, exp_o, denorm_o, zero_o};
    if (hold_pending)
      chk(v_o && (got == hold_val), "hold_stable", {8'h0, got}, {8'h0, hold_val});
    mready = (q.size() < 2) || yumi_i;
    chk(ready_o == mready, "ready_o", {31'h0, ready_o}, {31'h0, mready});
    if (v_o && q.size() == 0)
      chk(1'b0, "spurious_v_o", 32'h1, 32'h0);
    if (v_o && yumi_i && q.size() != 0) begin
      exp_item = q.pop_front();
      pops++;
      $display("pop %0d data=%h exp=%0d denorm=%b zero=%b", pops, data_o, exp_o, denorm_o, zero_o);
      chk(got == exp_item, "pop_item", {8'h0, got}, {8'h0, exp_item});
    end
    acc = v && mready;
    if (acc) q.push_back(ref_norm(d, s, e));
    hold_pending = v_o && !yumi_i;
    hold_val     = got;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b0;
    q.delete();
    hold_pending = 0;
    #1;
    chk(v_o == 1'b0, "reset_v_o", {31'h0, v_o}, 32'h0);
    chk(ready_o == 1'b1, "reset_ready_o", {31'h0, ready_o}, 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[7];
    vec_t        st[4];
    bit          acc;
    int          p;
    int          pops0;
    logic [15:0] rd;
    logic [3:0]  rs;
    logic [4:0]  re;

    reset_i = 1'b1; v_i = 0; yumi_i = 0; data_i = 0; shamt_i = 0; exp_i = 0;
    repeat (2) @(posedge clk_i);
    do_reset();

    // Vectors: {data, shamt, exp, exp_data, exp_exp, denorm, zero}
    vecs[0] = '{16'h0010, 4'd11, 5'd20, 16'h8000, 5'd9,  1'b0, 1'b0};
    vecs[1] = '{16'h0001, 4'd15, 5'd6,  16'h0040, 5'd0,  1'b1, 1'b0};
    vecs[2] = '{16'h0100, 4'd7,  5'd7,  16'h8000, 5'd0,  1'b1, 1'b0};
    vecs[3] = '{16'h0000, 4'd0,  5'd17, 16'h0000, 5'd0,  1'b0, 1'b1};
    vecs[4] = '{16'h0123, 4'd7,  5'd0,  16'h0123, 5'd0,  1'b1, 1'b0};
    vecs[5] = '{16'h8001, 4'd0,  5'd30, 16'h8001, 5'd30, 1'b0, 1'b0};
    vecs[6] = '{16'h00F0, 4'd8,  5'd31, 16'hF000, 5'd23, 1'b0, 1'b0};

    foreach (vecs[k]) begin
      tick(1'b1, vecs[k].d, vecs[k].s, vecs[k].e, 1'b1, acc);
      chk(acc, "vec_accept", {31'h0, acc}, 32'h1);
      tick(1'b0, 16'h0, 4'h0, 5'h0, 1'b1, acc);
      chk(v_o == 1'b0, "vec_latency_early", {31'h0, v_o}, 32'h0);
      tick(1'b0, 16'h0, 4'h0, 5'h0, 1'b1, acc);
      chk(v_o == 1'b1, "vec_latency_v_o", {31'h0, v_o}, 32'h1);
      chk(data_o == vecs[k].xd, "vec_data_o", {16'h0, data_o}, {16'h0, vecs[k].xd});
      chk(exp_o == vecs[k].xe, "vec_exp_o", {27'h0, exp_o}, {27'h0, vecs[k].xe});
      chk(denorm_o == vecs[k].xdn, "vec_denorm_o", {31'h0, denorm_o}, {31'h0, vecs[k].xdn});
      chk(zero_o == vecs[k].xz, "vec_zero_o", {31'h0, zero_o}, {31'h0, vecs[k].xz});
    end
    tick(1'b0, 16'h0, 4'h0, 5'h0, 1'b0, acc);

    // Stall: offer 4 items with yumi low; only 2 fit.
    st[0] = '{16'h0008, 4'd12, 5'd20, 16'h0, 5'h0, 1'b0, 1'b0};
    st[1] = '{16'h0300, 4'd6,  5'd4,  16'h0, 5'h0, 1'b0, 1'b0};
    st[2] = '{16'h1000, 4'd3,  5'd3,  16'h0, 5'h0, 1'b0, 1'b0};
    st[3] = '{16'h0055, 4'd9,  5'd18, 16'h0, 5'h0, 1'b0, 1'b0};
    p = 0;
    for (int c = 0; c < 4; c++) begin
      tick(1'b1, st[p].d, st[p].s, st[p].e, 1'b0, acc);
      if (acc) p++;
    end
    chk(p == 2, "stall_accepted", p, 2);
    chk(ready_o == 1'b0, "stall_ready_low", {31'h0, ready_o}, 32'h0);
    chk({data_o, exp_o, denorm_o, zero_o} == ref_norm(st[0].d, st[0].s, st[0].e),
        "stall_holds_item1", {9'h0, data_o, exp_o, denorm_o, zero_o},
        {9'h0, ref_norm(st[0].d, st[0].s, st[0].e)});
    pops0 = pops;
    for (int c = 0; c < 4; c++) begin
      tick(p < 4, st[p < 4 ? p : 3].d, st[p < 4 ? p : 3].s, st[p < 4 ? p : 3].e, 1'b1, acc);
      chk(v_o == 1'b1, "drain_v_o", {31'h0, v_o}, 32'h1);
      chk(ready_o == 1'b1, "drain_ready", {31'h0, ready_o}, 32'h1);
      if (acc) p++;
    end
    chk(pops - pops0 == 4, "drain_pop_count", pops - pops0, 4);
    chk(q.size() == 0, "drain_queue_empty", q.size(), 0);

    // Reset with two items in flight.
    tick(1'b1, 16'h0F00, 4'd4, 5'd10, 1'b0, acc);
    tick(1'b1, 16'h00F0, 4'd8, 5'd10, 1'b0, acc);
    do_reset();
    pops0 = pops;
    tick(1'b1, 16'h4000, 4'd1, 5'd3, 1'b1, acc);
    chk(acc, "post_reset_accept", {31'h0, acc}, 32'h1);
    for (int c = 0; c < 5; c++) tick(1'b0, 16'h0, 4'h0, 5'h0, 1'b1, acc);
    chk(pops - pops0 == 1, "post_reset_only_one", pops - pops0, 1);
    chk(q.size() == 0, "post_reset_queue_empty", q.size(), 0);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      rd = 16'($urandom) >> $urandom_range(0, 16);
      rs = (rd == 0) ? 4'($urandom_range(0, 15)) : 4'(clz16(rd));
      re = 5'($urandom);
      tick($urandom_range(0, 3) != 0, rd, rs, re, $urandom_range(0, 2) != 0, acc);
    end
    for (int c = 0; c < 20 && q.size() != 0; c++)
      tick(1'b0, 16'h0, 4'h0, 5'h0, 1'b1, acc);
    chk(q.size() == 0, "random_drain", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
